serial_mac_accumulator: RTL and testbench
=========================================

Name: serial_mac_accumulator

Overview:
- Time-multiplexed, parametrised successor to the binary-weight spike MAC.
- Captures a 2**N_STAGE-bit spike vector x, a sign-weight vector w and a new weight-enable mask m, giving ternary weights {-1, 0, +1}.
- Sums the products in chunks of 2**CHUNK_LOG2 synapses per cycle, trading latency for adder area.
- Uses valid/ready handshakes on input and output; sits between the synapse-weight store and the neuron membrane update.

Parameters:
- N_STAGE, 6: log2 of synapse count; N = 2**N_STAGE.
- CHUNK_LOG2, 3: log2 of synapses per cycle; C = 2**CHUNK_LOG2; legal range 0..N_STAGE.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  x/w/m valid.
- in_ready  out  1  block can accept a vector.
- x  in  N  spike bits.
- w  in  N  weight sign: 1 = +1, 0 = -1.
- m  in  N  weight enable: 0 forces the product to 0.
- out_valid  out  1  y_out valid.
- out_ready  in  1  consumer accepts y_out.
- y_out  out  N_STAGE+2  signed two's-complement sum.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, y_out=0.
  - Accumulator, chunk index and captured vectors all cleared.
- Per-synapse product for synapse i:
  - +1 if x[i]&m[i]&w[i].
  - -1 if x[i]&m[i]&~w[i].
  - 0 otherwise.
- Arithmetic width:
  - y range is -N..+N, held in N_STAGE+2 bits.
  - No overflow is possible, so no saturation logic.
  - Chunk partial is CHUNK_LOG2+2 bits signed, sign-extended before the add.
- FSM IDLE:
  - in_ready=1.
  - On in_valid&in_ready: register x, w, m; clear accumulator; chunk index k=0; go to ACCUM.
- FSM ACCUM:
  - in_ready=0.
  - Each cycle: acc += partial(chunk k), where chunk k covers bits [k*C +: C]; then k++.
  - On the cycle processing k = N/C-1, go to DONE; y_out is loaded with the final sum at the same edge.
  - k wraps to 0.
- FSM DONE:
  - out_valid=1; y_out held stable.
  - in_ready=0 (no overlap; one bubble between results).
  - On out_ready: out_valid=0, go to IDLE.
  - y_out keeps its last value until the next DONE load.
- Latency:
  - out_valid rises exactly N/C clock edges after the accepting edge.
  - CHUNK_LOG2=N_STAGE gives a latency of 1.
  - Throughput is one result per N/C+2 cycles with out_ready held high.
- Input stability: x/w/m are sampled only at the accept edge; later changes have no effect.
- Backpressure: out_ready=0 in DONE holds y_out and out_valid indefinitely.
- out_ready outside DONE is ignored.
- in_valid outside IDLE is ignored; the source must hold it until in_ready.
- Reset mid-operation: any state returns to IDLE immediately; the partial result is discarded and out_valid drops asynchronously.

Decomposition:
- Shared package (mac_pkg):
  - Width functions: acc width = N_STAGE+2; partial width = CHUNK_LOG2+2.
  - State encoding constants IDLE/ACCUM/DONE.
- Sub-module chunk_signed_popcount #(CHUNK_LOG2):
  - Combinational; inputs C-bit x/w/m.
  - Output is the signed partial sum, popcount(x&m&w) - popcount(x&m&~w).
  - Reused by later parallel variants.

Test Plan:
- N_STAGE=6, CHUNK_LOG2=3; x=all 1, w=all 1, m=all 1 -> y_out=+64 (0x40); out_valid exactly 8 edges after accept.
- Same, w=all 0 -> y_out=-64 (8'hC0). Then m=all 0, any x/w -> y_out=0.
- x=all 1, m=all 1, w=64'h5555_5555_5555_5555 -> y_out=0. Then w=64'h0000_0000_FFFF_FFFF with x=64'h0000_0000_0000_00FF -> y_out=+8.
- Backpressure:
  - Hold out_ready=0 for 20 cycles in DONE -> y_out/out_valid stable, in_ready=0.
  - Raise out_ready -> out_valid falls next edge, in_ready=1.
  - A second vector is accepted on the following cycle.
- Reset: assert rst_n=0 at chunk k=4 -> out_valid=0, in_ready=1 with no clock edge. Next vector (all +1) -> y_out=+64, unaffected by the aborted run.
- CHUNK_LOG2=6 build: all +1 -> y_out=+64 one edge after accept. CHUNK_LOG2=0 build -> latency 64 edges, same results as above.

Source files
------------

// File: rtl/serial_mac_accumulator_pkg.sv
`default_nettype none
// ============================================================================
// serial_mac_accumulator_pkg : FSM states and width helpers for the MAC
// Revision: 1.0
// ============================================================================
package serial_mac_accumulator_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_t;

   // The full sum spans -N..+N, which needs N_STAGE+2 signed bits.
   function automatic int acc_width(input int n_stage);
      return n_stage + 2;
   endfunction

   function automatic int partial_width(input int chunk_log2);
      return chunk_log2 + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/chunk_signed_popcount.sv
`default_nettype none
// ============================================================================
// chunk_signed_popcount : signed ternary-weight sum over one chunk of synapses
// Revision: 1.0
// ============================================================================
module chunk_signed_popcount
   import serial_mac_accumulator_pkg::*;
#(
   parameter int CHUNK_LOG2 = 3
) (
   input  logic [2**CHUNK_LOG2-1:0]                  i_x,
   input  logic [2**CHUNK_LOG2-1:0]                  i_w,
   input  logic [2**CHUNK_LOG2-1:0]                  i_m,
   output logic signed [partial_width(CHUNK_LOG2)-1:0] o_partial
);

   localparam int c_chunk = 2**CHUNK_LOG2;
   localparam int c_pw    = partial_width(CHUNK_LOG2);
   localparam logic signed [c_pw-1:0] c_one = c_pw'(1);

   always_comb begin
      o_partial = '0;
      for (int i = 0; i < c_chunk; i++) begin
         if (i_x[i] & i_m[i]) begin
            o_partial = i_w[i] ? (o_partial + c_one) : (o_partial - c_one);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/serial_mac_accumulator.sv
`default_nettype none
// ============================================================================
// serial_mac_accumulator : chunk-serial ternary-weight spike MAC, valid/ready
// Revision: 1.0
// ============================================================================
module serial_mac_accumulator
   import serial_mac_accumulator_pkg::*;
#(
   parameter int N_STAGE    = 6,
   parameter int CHUNK_LOG2 = 3
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [2**N_STAGE-1:0]         x,
   input  logic [2**N_STAGE-1:0]         w,
   input  logic [2**N_STAGE-1:0]         m,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [acc_width(N_STAGE)-1:0] y_out
);

   localparam int c_n      = 2**N_STAGE;
   localparam int c_c      = 2**CHUNK_LOG2;
   localparam int c_nchunk = c_n / c_c;
   localparam int c_aw     = acc_width(N_STAGE);
   localparam int c_pw     = partial_width(CHUNK_LOG2);
   // A single-chunk build still needs a 1-bit index to keep the selects legal.
   localparam int c_kw     = (N_STAGE > CHUNK_LOG2) ? (N_STAGE - CHUNK_LOG2) : 1;
   localparam logic [c_kw-1:0] c_k_last = c_kw'(c_nchunk - 1);

   state_t                   r_state;
   logic [c_n-1:0]           r_x;
   logic [c_n-1:0]           r_w;
   logic [c_n-1:0]           r_m;
   logic signed [c_aw-1:0]   r_acc;
   logic [c_kw-1:0]          r_k;

   logic [c_c-1:0]           w_chunk_x;
   logic [c_c-1:0]           w_chunk_w;
   logic [c_c-1:0]           w_chunk_m;
   logic signed [c_pw-1:0]   w_partial;
   logic signed [c_aw-1:0]   w_partial_ext;
   logic signed [c_aw-1:0]   w_acc_next;

   assign w_chunk_x = r_x[int'(r_k)*c_c +: c_c];
   assign w_chunk_w = r_w[int'(r_k)*c_c +: c_c];
   assign w_chunk_m = r_m[int'(r_k)*c_c +: c_c];

   chunk_signed_popcount #(
      .CHUNK_LOG2 (CHUNK_LOG2)
   ) u_chunk (
      .i_x       (w_chunk_x),
      .i_w       (w_chunk_w),
      .i_m       (w_chunk_m),
      .o_partial (w_partial)
   );

   // Signed size cast sign-extends the chunk partial into the accumulator width.
   assign w_partial_ext = c_aw'(w_partial);
   assign w_acc_next    = r_acc + w_partial_ext;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_x       <= '0;
         r_w       <= '0;
         r_m       <= '0;
         r_acc     <= '0;
         r_k       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         y_out     <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_x      <= x;
                  r_w      <= w;
                  r_m      <= m;
                  r_acc    <= '0;
                  r_k      <= '0;
                  in_ready <= 1'b0;
                  r_state  <= ACCUM;
               end
            end
            ACCUM: begin
               r_acc <= w_acc_next;
               if (r_k == c_k_last) begin
                  r_k       <= '0;
                  y_out     <= w_acc_next;
                  out_valid <= 1'b1;
                  r_state   <= DONE;
               end else begin
                  r_k <= r_k + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  r_state   <= IDLE;
               end
            end
            default: begin
               r_state   <= IDLE;
               in_ready  <= 1'b1;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_serial_mac_accumulator.sv
`default_nettype none
// ============================================================================
// tb_serial_mac_accumulator : three builds (C=8, C=64, C=1) against a
// latency-count transaction model; directed vectors plus randomized traffic.
// Revision: 1.0
// ============================================================================
module tb_serial_mac_accumulator;

   localparam int c_nd = 3;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [63:0] x, w, m;
   logic        in_valid_a  [c_nd];
   logic        in_ready_a  [c_nd];
   logic        out_valid_a [c_nd];
   logic        out_ready_a [c_nd];
   logic [7:0]  y_a         [c_nd];

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   function automatic int cl_of(input int d);
      return (d == 0) ? 3 : ((d == 1) ? 6 : 0);
   endfunction

   function automatic int lat_of(input int d);
      return 64 >> cl_of(d);
   endfunction

   generate
      for (genvar g = 0; g < c_nd; g++) begin : g_dut
         serial_mac_accumulator #(
            .N_STAGE    (6),
            .CHUNK_LOG2 (cl_of(g))
         ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid_a[g]),
            .in_ready  (in_ready_a[g]),
            .x         (x),
            .w         (w),
            .m         (m),
            .out_valid (out_valid_a[g]),
            .out_ready (out_ready_a[g]),
            .y_out     (y_a[g])
         );
      end
   endgenerate

   // Reference sum straight from the ternary product rule.
   function automatic int ref_sum(input logic [63:0] xv, input logic [63:0] wv,
                                  input logic [63:0] mv);
      int s = 0;
      for (int i = 0; i < 64; i++) begin
         if (xv[i] && mv[i]) s += wv[i] ? 1 : -1;
      end
      return s;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Transaction model: a result appears lat_of(d) edges after acceptance.
   logic m_busy  [c_nd];
   logic m_valid [c_nd];
   int   m_cnt   [c_nd];
   int   m_pend  [c_nd];
   int   m_y     [c_nd];

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int d = 0; d < c_nd; d++) begin
            m_busy[d]  <= 1'b0;
            m_valid[d] <= 1'b0;
            m_cnt[d]   <= 0;
            m_pend[d]  <= 0;
            m_y[d]     <= 0;
         end
      end else begin
         for (int d = 0; d < c_nd; d++) begin
            if (m_busy[d]) begin
               if (m_cnt[d] + 1 == lat_of(d)) begin
                  m_busy[d]  <= 1'b0;
                  m_valid[d] <= 1'b1;
                  m_y[d]     <= m_pend[d];
               end else begin
                  m_cnt[d] <= m_cnt[d] + 1;
               end
            end else if (m_valid[d]) begin
               if (out_ready_a[d]) m_valid[d] <= 1'b0;
            end else if (in_valid_a[d]) begin
               m_busy[d] <= 1'b1;
               m_cnt[d]  <= 0;
               m_pend[d] <= ref_sum(x, w, m);
            end
         end
      end
   end

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1) begin
            for (int d = 0; d < c_nd; d++) begin
               check($sformatf("dut%0d in_ready", d), int'(in_ready_a[d]),
                     int'(!m_busy[d] && !m_valid[d]));
               check($sformatf("dut%0d out_valid", d), int'(out_valid_a[d]),
                     int'(m_valid[d]));
               check($sformatf("dut%0d y_out", d), int'($signed(y_a[d])), m_y[d]);
            end
         end
      end
   end

   // Called at posedge+1; accepts one vector and pins latency and result.
   task automatic run_vec(input int d, input logic [63:0] xv, input logic [63:0] wv,
                          input logic [63:0] mv, input int exp, input int hold,
                          input string name);
      int lat;
      int guard;
      x = xv;
      w = wv;
      m = mv;
      in_valid_a[d] = 1'b1;
      guard = 0;
      while (!in_ready_a[d] && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!in_ready_a[d]) check({name, " accept timeout"}, 0, 1);
      @(posedge clk); #1;
      in_valid_a[d] = 1'b0;
      lat = 0;
      while (!out_valid_a[d] && lat < 200) begin
         @(posedge clk); #1;
         lat++;
      end
      check({name, " latency"}, lat, lat_of(d));
      check({name, " y"}, int'($signed(y_a[d])), exp);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check({name, " hold out_valid"}, int'(out_valid_a[d]), 1);
         check({name, " hold y"}, int'($signed(y_a[d])), exp);
         check({name, " hold in_ready"}, int'(in_ready_a[d]), 0);
      end
      out_ready_a[d] = 1'b1;
      @(posedge clk); #1;
      out_ready_a[d] = 1'b0;
      check({name, " out_valid drop"}, int'(out_valid_a[d]), 0);
      check({name, " in_ready back"}, int'(in_ready_a[d]), 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   logic [63:0] ones;
   logic [63:0] v;
   bit          acc;
   int          guard;

   initial begin
      ones  = '1;
      rst_n = 1'b1;
      x = '0; w = '0; m = '0;
      for (int d = 0; d < c_nd; d++) begin
         in_valid_a[d]  = 1'b0;
         out_ready_a[d] = 1'b0;
      end
      #1 rst_n = 1'b0;
      #1;
      for (int d = 0; d < c_nd; d++) begin
         check($sformatf("dut%0d reset in_ready", d), int'(in_ready_a[d]), 1);
         check($sformatf("dut%0d reset out_valid", d), int'(out_valid_a[d]), 0);
         check($sformatf("dut%0d reset y", d), int'($signed(y_a[d])), 0);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Directed vectors on the C=8 build.
      run_vec(0, ones, ones, ones, 64, 0, "all_pos");
      run_vec(0, ones, 64'h0, ones, -64, 0, "all_neg");
      v = {$urandom, $urandom};
      run_vec(0, v, {$urandom, $urandom}, 64'h0, 0, 0, "mask_zero");
      run_vec(0, ones, 64'h5555_5555_5555_5555, ones, 0, 0, "alternating");
      run_vec(0, 64'h0000_0000_0000_00FF, 64'h0000_0000_FFFF_FFFF, ones, 8, 20, "backpressure");
      run_vec(0, ones, ones, ones, 64, 0, "back_to_back");

      // Async reset in the middle of accumulation (k = 4).
      x = ones; w = 64'h0; m = ones;
      in_valid_a[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_a[0] = 1'b0;
      repeat (4) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrun reset in_ready", int'(in_ready_a[0]), 1);
      check("midrun reset out_valid", int'(out_valid_a[0]), 0);
      check("midrun reset y", int'($signed(y_a[0])), 0);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      run_vec(0, ones, ones, ones, 64, 0, "after_abort");

      // Async reset while a result is waiting in DONE.
      x = ones; w = 64'h0; m = ones;
      in_valid_a[0] = 1'b1;
      @(posedge clk); #1;
      in_valid_a[0] = 1'b0;
      guard = 0;
      while (!out_valid_a[0] && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("done pre-reset y", int'($signed(y_a[0])), -64);
      #2 rst_n = 1'b0;
      #1;
      check("done reset out_valid", int'(out_valid_a[0]), 0);
      check("done reset in_ready", int'(in_ready_a[0]), 1);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;

      // Other chunk sizes.
      run_vec(1, ones, ones, ones, 64, 0, "c64_all_pos");
      run_vec(1, 64'h0000_0000_0000_00FF, 64'h0000_0000_FFFF_FFFF, ones, 8, 3, "c64_plus8");
      run_vec(2, ones, ones, ones, 64, 0, "c1_all_pos");
      run_vec(2, ones, 64'h0, ones, -64, 0, "c1_all_neg");
      run_vec(2, ones, 64'h5555_5555_5555_5555, ones, 0, 0, "c1_alternating");

      // Randomized traffic with random backpressure on the C=8 build.
      for (int c = 0; c < 600; c++) begin
         acc = in_valid_a[0] && in_ready_a[0];
         @(posedge clk); #1;
         if (acc || !in_valid_a[0]) begin
            in_valid_a[0] = ($urandom_range(0, 3) != 0);
            x = {$urandom, $urandom};
            w = {$urandom, $urandom};
            m = {$urandom, $urandom};
            case ($urandom_range(0, 5))
               0: begin x = ones; m = ones; end
               1: begin x = ones; m = ones; w = ones; end
               2: begin x = ones; m = ones; w = 64'h0; end
               default: ;
            endcase
         end
         out_ready_a[0] = ($urandom_range(0, 2) != 0);
      end
      in_valid_a[0]  = 1'b0;
      out_ready_a[0] = 1'b1;
      repeat (30) @(posedge clk);
      #1 out_ready_a[0] = 1'b0;
      @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
